// File: rtl/baud_rate_generator.sv
// baud_rate_generator: programmable divisor producing registered sample (rx) and bit (tx) rate ticks.
// Define BAUD_RESYNC_EN to add the resync input that recentres the sample phase on a start edge.
module baud_rate_generator #(
    parameter int CNT_W   = 16,
    parameter int OVS     = 16,
    parameter int RST_DIV = 122
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_wr_lo,
    input  logic             div_wr_hi,
    input  logic [7:0]       div_data,
`ifdef BAUD_RESYNC_EN
    input  logic             resync,
`endif
    output logic [CNT_W-1:0] div_q,
    output logic             rx_tick,
    output logic             tx_tick
);
    localparam logic [3:0] OCNT_TOP = 4'(OVS - 1);
    logic [CNT_W-1:0] div_q_q, div_d, cnt_q, cnt_d;
    logic [3:0]       ocnt_q, ocnt_d;
    logic             rx_q, rx_d, tx_q, tx_d;
    logic             wr, rs, fire;
`ifdef BAUD_RESYNC_EN
    assign rs = resync;
`else
    assign rs = 1'b0;
`endif
    assign wr   = div_wr_lo | div_wr_hi;
    assign fire = en && cnt_q == '0 && !wr && !rs;
    always_comb begin
        div_d = div_q_q;
        if (div_wr_lo) div_d[7:0] = div_data;
        if (div_wr_hi) div_d[CNT_W-1:8] = div_data[CNT_W-9:0];
    end
    // write beats resync beats the enabled count; everything else holds
    always_comb begin
        cnt_d  = wr ? div_d : rs ? div_q_q >> 1 : !en ? cnt_q : fire ? div_q_q : cnt_q - 1'b1;
        ocnt_d = (wr || rs) ? OCNT_TOP : !fire ? ocnt_q : ocnt_q == 4'd0 ? OCNT_TOP : ocnt_q - 4'd1;
        rx_d   = fire;
        tx_d   = fire && ocnt_q == 4'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q_q <= CNT_W'(RST_DIV);
            cnt_q   <= CNT_W'(RST_DIV);
            ocnt_q  <= OCNT_TOP;
            rx_q    <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            div_q_q <= div_d;
            cnt_q   <= cnt_d;
            ocnt_q  <= ocnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
        end
    end
    assign div_q   = div_q_q;
    assign rx_tick = rx_q;
    assign tx_tick = tx_q;
endmodule

// File: tb/tb_baud_rate_generator.sv
// tb_baud_rate_generator: directed checks of divisor, tick periods, enable, writes, reset and resync.
module tb_baud_rate_generator;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b1, wr_lo = 1'b0, wr_hi = 1'b0, resync = 1'b0;
    logic [7:0]  data = 8'd0;
    logic [15:0] div_q;
    logic        rx_tick, tx_tick, rx4, tx4;
    logic [15:0] div4;
    int          checks = 0, failures = 0, n = 0;
    always #5 clk = ~clk;
    baud_rate_generator dut (
        .clk(clk), .rst(rst), .en(en), .div_wr_lo(wr_lo), .div_wr_hi(wr_hi), .div_data(data),
`ifdef BAUD_RESYNC_EN
        .resync(resync),
`endif
        .div_q(div_q), .rx_tick(rx_tick), .tx_tick(tx_tick)
    );
    // second instance: divisor 0 with four samples per bit
    baud_rate_generator #(.OVS(4), .RST_DIV(0)) dut4 (
        .clk(clk), .rst(rst), .en(1'b1), .div_wr_lo(1'b0), .div_wr_hi(1'b0), .div_data(8'd0),
`ifdef BAUD_RESYNC_EN
        .resync(1'b0),
`endif
        .div_q(div4), .rx_tick(rx4), .tx_tick(tx4)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask
    task automatic wait_rx(output int c);
        c = 0;
        do begin step(1); c++; end while (!rx_tick && c < 5000);
    endtask
    task automatic wait_tx(output int c);
        c = 0;
        do begin step(1); c++; end while (!tx_tick && c < 5000);
    endtask
    // a bit tick must always coincide with a sample tick
    always @(negedge clk) begin
        checks++;
        assert (!tx_tick || rx_tick) else begin
            failures++;
            $error("FAIL tx_without_rx observed=%0d expected=%0d", rx_tick, 1);
        end
    end
    initial begin
        step(3);
        chk("rst_div", div_q, 122);
        chk("rst_rx", rx_tick, 0);
        chk("rst_tx", tx_tick, 0);
        chk("rst_div4", div4, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("ovs4_rx", rx4, 1);
            chk("ovs4_tx", tx4, (i % 4 == 3) ? 1 : 0);
            chk("early_rx", rx_tick, 0);
        end
        wait_rx(n); chk("first_rx", n, 115);
        wait_rx(n); chk("rx_period", n, 123);
        wait_tx(n); chk("first_tx", n, 1722);
        wait_tx(n); chk("tx_period", n, 1968);
        wr_lo = 1'b1; data = 8'h04;
        step(1); chk("wr_lo_div", div_q, 4); chk("wr_lo_rx", rx_tick, 0); chk("wr_lo_tx", tx_tick, 0);
        wr_lo = 1'b0; wr_hi = 1'b1; data = 8'h00;
        step(1); chk("wr_hi_div", div_q, 4); chk("wr_hi_rx", rx_tick, 0); chk("wr_hi_tx", tx_tick, 0);
        wr_hi = 1'b0;
        wait_rx(n); chk("div4_rx1", n, 5);
        wait_rx(n); chk("div4_rx2", n, 5);
        wait_tx(n); chk("div4_tx1", n, 70);
        wait_tx(n); chk("div4_tx2", n, 80);
        step(4); chk("pre_zero_rx", rx_tick, 0);
        wr_lo = 1'b1; data = 8'h04;
        step(1); chk("wr_at_zero_rx", rx_tick, 0);
        wr_lo = 1'b0;
        wait_rx(n); chk("after_zero_wr", n, 5);
        step(2); en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("en_low_rx", rx_tick, 0);
            chk("en_low_tx", tx_tick, 0);
        end
        en = 1'b1;
        wait_rx(n); chk("en_resume", 12 + n, 15);
        en = 1'b0; wr_lo = 1'b1; data = 8'h09;
        step(1); chk("wr_en_low_div", div_q, 9); chk("wr_en_low_rx", rx_tick, 0);
        wr_lo = 1'b0; en = 1'b1;
        wait_rx(n); chk("div9_rx", n, 10);
        wr_lo = 1'b1; wr_hi = 1'b1; data = 8'h02;
        step(1); chk("wr_both_div", div_q, 16'h0202);
        wr_lo = 1'b0; wr_hi = 1'b0;
        step(7);
        rst = 1'b1; wr_lo = 1'b1; data = 8'h55;
        step(1); chk("rst_wr_div", div_q, 122); chk("rst_mid_rx", rx_tick, 0);
        rst = 1'b0; wr_lo = 1'b0;
        wait_rx(n); chk("rst_mid_first_rx", n, 123);
`ifdef BAUD_RESYNC_EN
        wr_lo = 1'b1; data = 8'h09;
        step(1); chk("rs_div", div_q, 9);
        wr_lo = 1'b0;
        step(3); resync = 1'b1;
        step(1); chk("rs_rx", rx_tick, 0);
        resync = 1'b0;
        wait_rx(n); chk("rs_first_rx", n, 5);
        wait_tx(n); chk("rs_first_tx", n, 150);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
